// File: rtl/mem_resp_pkg.sv
// Shared definitions for the unified memory responder.
// Contents: loader/CPU service FSM encoding, word geometry and byte-lane placement helper.
package mem_resp_pkg;

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;

  // Lane index of the most significant byte of a word.
  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

  // Bit offset of byte lane `lane` within a little-endian word.
  function automatic logic [4:0] lane_shift(input logic [1:0] lane);
    return 5'(lane) * 5'(BYTE_W);
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// Word-organised storage: one synchronous write port, one asynchronous read port.
// Ports:
//   clk    - write clock (rising edge)
//   we     - write enable
//   waddr  - write word index
//   wdata  - write data
//   raddr  - read word index
//   rdata  - combinational read data
// Contents are not reset.
module mem_word_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/unified_mem_responder.sv
// Memory-side responder for a multicycle RV32I core with one unified memory port.
// After reset a byte-stream loader fills the array while the core is held in reset; the
// final loader byte hands the array over to the core.
// Ports:
//   clk, reset           - clock, asynchronous active-low reset
//   cpu_addr/wdata/we    - core byte address, store data, store strobe
//   cpu_rdata            - combinational read data (0 while loading or out of range)
//   cpu_run              - core runs when 1
//   ld_valid/byte/last   - loader byte stream (little-endian within each word)
//   ld_ready             - loader may transfer
//   ld_words             - words written by the loader (saturates at DEPTH_WORDS)
//   fault                - sticky: loader overflow or bad CPU store
module unified_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_we,
  output logic [31:0] cpu_rdata,
  output logic        cpu_run,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic [AW:0] ld_words,
  output logic        fault
);

  localparam logic [AW:0] LD_FULL_CNT = (AW + 1)'(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] asm_q, asm_d;
  logic [AW:0] ld_words_q, ld_words_d;
  logic        fault_q, fault_d;

  logic        accept;
  logic        word_done;
  logic        ld_full;
  logic [31:0] asm_merged;
  logic        addr_in_range;
  logic        addr_aligned;
  logic        cpu_store;
  logic        cpu_store_ok;
  logic        arr_we;
  logic [AW-1:0] arr_waddr;
  logic [31:0] arr_wdata;
  logic [31:0] arr_rdata;

  // Loader datapath
  assign accept     = ld_valid & ld_ready;
  assign word_done  = accept & ((byte_cnt_q == LAST_LANE) | ld_last);
  assign ld_full    = (ld_words_q == LD_FULL_CNT);
  // Upper lanes of a partial word are still zero from the previous clear.
  assign asm_merged = asm_q | ({24'b0, ld_byte} << lane_shift(byte_cnt_q));

  // CPU address checks
  assign addr_in_range = (cpu_addr[31:AW+2] == '0);
  assign addr_aligned  = (cpu_addr[1:0] == 2'b00);
  assign cpu_store     = (state_q == RUN) & cpu_we;
  assign cpu_store_ok  = cpu_store & addr_in_range & addr_aligned;

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (state_q == LOAD && accept && ld_last) begin
      state_d = RUN;
    end
  end

  // FSM outputs: cpu_run comes straight from the state flop.
  always_comb begin
    ld_ready = (state_q == LOAD);
    cpu_run  = (state_q == RUN);
  end

  // Loader counters and fault next state
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    ld_words_d = ld_words_q;
    fault_d    = fault_q;
    if (accept) begin
      if (word_done) begin
        byte_cnt_d = 2'd0;
        asm_d      = 32'd0;
      end else begin
        byte_cnt_d = byte_cnt_q + 2'd1;
        asm_d      = asm_merged;
      end
    end
    if (word_done && !ld_full) begin
      ld_words_d = ld_words_q + 1'b1;
    end
    if ((word_done && ld_full) || (cpu_store && !cpu_store_ok)) begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt_q <= 2'd0;
      asm_q      <= 32'd0;
      ld_words_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      ld_words_q <= ld_words_d;
      fault_q    <= fault_d;
    end
  end

  // Write port belongs to the loader in LOAD and to the core in RUN.
  always_comb begin
    if (state_q == LOAD) begin
      arr_we    = word_done & ~ld_full;
      arr_waddr = ld_words_q[AW-1:0];
      arr_wdata = asm_merged;
    end else begin
      arr_we    = cpu_store_ok;
      arr_waddr = cpu_addr[AW+1:2];
      arr_wdata = cpu_wdata;
    end
  end

  mem_word_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .raddr (cpu_addr[AW+1:2]),
    .rdata (arr_rdata)
  );

  assign cpu_rdata = ((state_q == RUN) && addr_in_range) ? arr_rdata : 32'd0;
  assign ld_words  = ld_words_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_unified_mem_responder.sv
module tb_unified_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic [31:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
  logic        cpu_we = 1'b0, cpu_run;
  logic        ld_valid = 1'b0, ld_last = 1'b0, ld_ready;
  logic [7:0]  ld_byte = '0;
  logic [10:0] ld_words;
  logic        fault;

  logic [31:0] s_cpu_addr = '0, s_cpu_wdata = '0, s_cpu_rdata;
  logic        s_cpu_we = 1'b0, s_cpu_run;
  logic        s_ld_valid = 1'b0, s_ld_last = 1'b0, s_ld_ready;
  logic [7:0]  s_ld_byte = '0;
  logic [2:0]  s_ld_words;
  logic        s_fault;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  unified_mem_responder dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .cpu_rdata (cpu_rdata),
    .cpu_run   (cpu_run),
    .ld_valid  (ld_valid),
    .ld_byte   (ld_byte),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .ld_words  (ld_words),
    .fault     (fault)
  );

  unified_mem_responder #(
    .DEPTH_WORDS(4)
  ) dut_small (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (s_cpu_addr),
    .cpu_wdata (s_cpu_wdata),
    .cpu_we    (s_cpu_we),
    .cpu_rdata (s_cpu_rdata),
    .cpu_run   (s_cpu_run),
    .ld_valid  (s_ld_valid),
    .ld_byte   (s_ld_byte),
    .ld_last   (s_ld_last),
    .ld_ready  (s_ld_ready),
    .ld_words  (s_ld_words),
    .fault     (s_fault)
  );

  task automatic send_byte(input logic [7:0] b, input logic last);
    @(negedge clk);
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
  endtask

  task automatic idle_loader;
    @(negedge clk);
    ld_valid = 1'b0;
    ld_byte  = 8'h00;
    ld_last  = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    @(negedge clk);
    cpu_addr = a;
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset;
    #1;
    n_checks++;
    if (cpu_run !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_run got %b want 0", cpu_run); end
    n_checks++;
    if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ld_ready got %b want 1", ld_ready); end
    n_checks++;
    if (ld_words !== 11'd0) begin n_fail++; $display("FAIL reset_ld_words got %0d want 0", ld_words); end
    n_checks++;
    if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got %b want 0", fault); end
    n_checks++;
    if (cpu_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", cpu_rdata); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_load_two_words;
    logic [7:0] img [8];
    img = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
    for (int i = 0; i < 7; i++) send_byte(img[i], 1'b0);
    send_byte(img[7], 1'b1);
    n_checks++;
    if (cpu_run !== 1'b0) begin n_fail++; $display("FAIL run_early got %b want 0", cpu_run); end
    idle_loader();
    n_checks++;
    if (cpu_run !== 1'b1) begin n_fail++; $display("FAIL run_rise got %b want 1", cpu_run); end
    n_checks++;
    if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL run_ld_ready got %b want 0", ld_ready); end
    n_checks++;
    if (ld_words !== 11'd2) begin n_fail++; $display("FAIL load2_words got %0d want 2", ld_words); end
    rd(32'h0);
    n_checks++;
    if (cpu_rdata !== 32'h00A00513) begin n_fail++; $display("FAIL load2_w0 got %h want 00a00513", cpu_rdata); end
    rd(32'h4);
    n_checks++;
    if (cpu_rdata !== 32'h00B00593) begin n_fail++; $display("FAIL load2_w1 got %h want 00b00593", cpu_rdata); end
    // Loader traffic in RUN must be ignored.
    send_byte(8'h55, 1'b1);
    idle_loader();
    n_checks++;
    if (ld_words !== 11'd2) begin n_fail++; $display("FAIL run_ignore_ld got %0d want 2", ld_words); end
    rd(32'h0);
    n_checks++;
    if (cpu_rdata !== 32'h00A00513) begin n_fail++; $display("FAIL run_ignore_w0 got %h want 00a00513", cpu_rdata); end
  endtask

  task automatic test_store;
    @(negedge clk);
    cpu_addr = 32'h10; cpu_wdata = 32'h12345678; cpu_we = 1'b1;
    @(negedge clk);
    cpu_wdata = 32'hDEADBEEF;
    #1;
    n_checks++;
    if (cpu_rdata !== 32'h12345678) begin n_fail++; $display("FAIL store_old got %h want 12345678", cpu_rdata); end
    @(negedge clk);
    cpu_we = 1'b0;
    #1;
    n_checks++;
    if (cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL store_new got %h want deadbeef", cpu_rdata); end
    n_checks++;
    if (fault !== 1'b0) begin n_fail++; $display("FAIL store_fault got %b want 0", fault); end
    rd(32'h13);
    n_checks++;
    if (cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_lowbits got %h want deadbeef", cpu_rdata); end
  endtask

  task automatic test_misaligned;
    @(negedge clk);
    cpu_addr = 32'h12; cpu_wdata = 32'hBADBAD00; cpu_we = 1'b1;
    @(negedge clk);
    cpu_we = 1'b0; cpu_addr = 32'h10;
    #1;
    n_checks++;
    if (cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL misal_data got %h want deadbeef", cpu_rdata); end
    n_checks++;
    if (fault !== 1'b1) begin n_fail++; $display("FAIL misal_fault got %b want 1", fault); end
  endtask

  task automatic test_partial_and_oor;
    do_reset();
    n_checks++;
    if (fault !== 1'b0) begin n_fail++; $display("FAIL rst_clear_fault got %b want 0", fault); end
    // A store attempted during LOAD must not land.
    @(negedge clk);
    cpu_addr = 32'h4; cpu_wdata = 32'hFFFFFFFF; cpu_we = 1'b1;
    send_byte(8'hAA, 1'b0);
    #1;
    n_checks++;
    if (cpu_rdata !== 32'd0) begin n_fail++; $display("FAIL load_rdata got %h want 0", cpu_rdata); end
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    idle_loader();
    cpu_we = 1'b0;
    n_checks++;
    if (ld_words !== 11'd1) begin n_fail++; $display("FAIL part_words got %0d want 1", ld_words); end
    rd(32'h0);
    n_checks++;
    if (cpu_rdata !== 32'h00CCBBAA) begin n_fail++; $display("FAIL part_w0 got %h want 00ccbbaa", cpu_rdata); end
    rd(32'h4);
    n_checks++;
    if (cpu_rdata !== 32'h00B00593) begin n_fail++; $display("FAIL load_store_ign got %h want 00b00593", cpu_rdata); end
    n_checks++;
    if (fault !== 1'b0) begin n_fail++; $display("FAIL part_fault got %b want 0", fault); end
    @(negedge clk);
    cpu_addr = 32'h1000; cpu_wdata = 32'hCAFEF00D; cpu_we = 1'b1;
    @(negedge clk);
    cpu_we = 1'b0;
    #1;
    n_checks++;
    if (fault !== 1'b1) begin n_fail++; $display("FAIL oor_fault got %b want 1", fault); end
    n_checks++;
    if (cpu_rdata !== 32'd0) begin n_fail++; $display("FAIL oor_rdata got %h want 0", cpu_rdata); end
    rd(32'h0);
    n_checks++;
    if (cpu_rdata !== 32'h00CCBBAA) begin n_fail++; $display("FAIL oor_alias got %h want 00ccbbaa", cpu_rdata); end
  endtask

  task automatic test_reset_midload;
    logic [7:0] img [4];
    img = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    for (int i = 0; i < 5; i++) send_byte(8'(i + 1), 1'b0);
    @(negedge clk);
    ld_valid = 1'b0;
    n_checks++;
    if (cpu_run !== 1'b0) begin n_fail++; $display("FAIL mid_run_pre got %b want 0", cpu_run); end
    reset = 1'b0;
    #1;
    n_checks++;
    if (cpu_run !== 1'b0) begin n_fail++; $display("FAIL mid_run_rst got %b want 0", cpu_run); end
    n_checks++;
    if (ld_words !== 11'd0) begin n_fail++; $display("FAIL mid_words_rst got %0d want 0", ld_words); end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) send_byte(img[i], 1'b0);
    send_byte(img[3], 1'b1);
    idle_loader();
    n_checks++;
    if (ld_words !== 11'd1) begin n_fail++; $display("FAIL reload_words got %0d want 1", ld_words); end
    n_checks++;
    if (cpu_run !== 1'b1) begin n_fail++; $display("FAIL reload_run got %b want 1", cpu_run); end
    rd(32'h0);
    n_checks++;
    if (cpu_rdata !== 32'h44332211) begin n_fail++; $display("FAIL reload_w0 got %h want 44332211", cpu_rdata); end
    rd(32'h4);
    n_checks++;
    if (cpu_rdata !== 32'h00B00593) begin n_fail++; $display("FAIL reload_w1 got %h want 00b00593", cpu_rdata); end
  endtask

  task automatic test_overflow;
    logic [31:0] exp_w [4];
    exp_w = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 16) begin
        n_checks++;
        if (s_fault !== 1'b0 || s_ld_words !== 3'd4) begin
          n_fail++;
          $display("FAIL ovf_pre got fault=%b words=%0d want fault=0 words=4", s_fault, s_ld_words);
        end
      end
      s_ld_valid = 1'b1;
      s_ld_byte  = 8'(i + 1);
      s_ld_last  = (i == 19);
    end
    @(negedge clk);
    s_ld_valid = 1'b0; s_ld_last = 1'b0;
    n_checks++;
    if (s_ld_words !== 3'd4) begin n_fail++; $display("FAIL ovf_words got %0d want 4", s_ld_words); end
    n_checks++;
    if (s_fault !== 1'b1) begin n_fail++; $display("FAIL ovf_fault got %b want 1", s_fault); end
    n_checks++;
    if (s_cpu_run !== 1'b1) begin n_fail++; $display("FAIL ovf_run got %b want 1", s_cpu_run); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      s_cpu_addr = 32'(k * 4);
      #1;
      n_checks++;
      if (s_cpu_rdata !== exp_w[k]) begin
        n_fail++;
        $display("FAIL ovf_word%0d got %h want %h", k, s_cpu_rdata, exp_w[k]);
      end
    end
    @(negedge clk);
    s_cpu_addr = 32'h10;
    #1;
    n_checks++;
    if (s_cpu_rdata !== 32'd0) begin n_fail++; $display("FAIL small_oor got %h want 0", s_cpu_rdata); end
  endtask

  initial begin
    test_reset();
    test_load_two_words();
    test_store();
    test_misaligned();
    test_partial_and_oor();
    test_reset_midload();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/unified_mem_responder.md
# unified_mem_responder

- Memory-side responder for the multicycle RV32I core's single memory port: it serves the core's unified instruction/data address, write data and write enable, and returns read data.
- It contains a byte-stream program loader that fills the array after reset.
- It holds the core in reset (`cpu_run` low) until loading completes, then switches the array to CPU service.
- It sits beside the CPU top level in the system wrapper.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024 — number of 32-bit words; power of two, ≥ 4.
- `AW`, log2(`DEPTH_WORDS`) — word-index width (derived, not overridden).

Ports:
- `clk` in 1 — single clock, rising edge.
- `reset` in 1 — asynchronous, active-low reset.
- `cpu_addr` in 32 — byte address from the core's memory-address output.
- `cpu_wdata` in 32 — store data from the core.
- `cpu_we` in 1 — store strobe from the core's MemWrite.
- `cpu_rdata` out 32 — read data to the core's memory read-data input.
- `cpu_run` out 1 — drives the core's reset (core runs when 1).
- `ld_valid` in 1 — loader byte valid.
- `ld_byte` in 8 — loader byte, little-endian within each word.
- `ld_last` in 1 — marks the final byte of the image.
- `ld_ready` out 1 — loader may transfer.
- `ld_words` out AW+1 — number of words written by the loader.
- `fault` out 1 — sticky store fault.

## Operation
- FSM states: LOAD, RUN.
  - Reset enters LOAD.
  - LOAD → RUN on an accepted byte with `ld_last=1`.
  - RUN is terminal until reset.
- LOAD:
  - `ld_ready`=1.
  - A byte is accepted on any edge with `ld_valid & ld_ready`.
  - A 2-bit byte counter places bytes 0..3 into lanes [7:0]..[31:24] of an assembly register.
  - On acceptance of byte 3, or of any byte with `ld_last`, the assembled word is written at index `ld_words` and `ld_words` increments.
  - Unfilled upper lanes of a partial final word are written as 0.
  - After the word write the assembly register and counter clear.
- Loader overflow: a word write when `ld_words == DEPTH_WORDS` is dropped and sets `fault`. `ld_words` saturates at `DEPTH_WORDS`.
- In LOAD, `cpu_we` is ignored and `cpu_rdata`=0.
- RUN:
  - `ld_ready`=0 and loader inputs are ignored.
  - `cpu_run`=1, registered, so it is asserted the cycle after the last byte is accepted.
- Read path (RUN): `cpu_rdata` is a combinational read of word `cpu_addr[AW+1:2]`.
  - `cpu_addr[1:0]` is ignored on reads.
  - If `cpu_addr >= 4*DEPTH_WORDS`, `cpu_rdata`=0 and no fault is raised. The core presents PC/ALU values here every cycle, so reads never fault.
- Store path (RUN): when `cpu_we`=1, a word write happens at the rising edge only if the address is in range and `cpu_addr[1:0]`=0.
  - Otherwise the store is suppressed and `fault` sets.
  - Full-word stores only.
- `fault` clears only on reset.

## Timing
- Reset values:
  - FSM=LOAD, `cpu_run`=0, `ld_ready`=1, `ld_words`=0, `fault`=0, `cpu_rdata`=0.
  - Byte counter and assembly register are 0.
  - Array contents are NOT reset.
- Loader throughput: one byte per cycle; a word is written on the same edge its last byte is accepted.
- `cpu_run` rises one edge after the `ld_last` byte edge. The core's first fetch is the cycle after that, and sees the final word.
- Read latency: 0 cycles (combinational).
- Store lands at the edge where `cpu_we`=1. A read of the same address in that cycle returns the old data; the next cycle returns the new data.
- Reset asserted mid-load:
  - Pointer, counter and assembly register clear; `cpu_run` is forced 0.
  - Already-written words persist and are overwritten by the next load.
- Reset in RUN: returns to LOAD and a full reload is required.
- `ld_valid` while `ld_ready`=0: ignored, no side effects.
- `ld_last` on byte 3: a single full-word write, with no extra zero word.

## Structure
- Shared package `mem_resp_pkg`:
  - FSM enum `{LOAD, RUN}`.
  - `BYTES_PER_WORD`=4.
  - Lane/shift constants for byte placement.
- Sub-module `mem_word_array`:
  - Synchronous single write port (`we`, `waddr`, `wdata`), one asynchronous read port.
  - Write port muxed between loader (LOAD) and CPU (RUN) by the parent.
- Parent holds the FSM, loader counters, range/alignment checks and fault logic.

## Test plan
- Load bytes 13 05 A0 00 | 93 05 B0 00 with `ld_last` on the final byte:
  - `ld_words`=2.
  - Word0=0x00A00513, word1=0x00B00593.
  - `cpu_run` rises exactly one cycle after the last byte.
- Load 3 bytes AA BB CC with `ld_last`: word0=0x00CCBBAA, `ld_words`=1.
- RUN, store 0xDEADBEEF at 0x10:
  - Same-cycle `cpu_rdata` shows the old value; the next cycle shows 0xDEADBEEF.
  - `fault`=0.
- RUN, store at 0x12 (misaligned), then a store at 4*`DEPTH_WORDS`:
  - Both suppressed and `fault`=1.
  - A read at 0x1000 (out of range, default `DEPTH_WORDS`) returns 0.
- Assert `reset` after 5 of 8 bytes; reload 4 bytes 11 22 33 44 + `ld_last`:
  - `ld_words`=1, word0=0x44332211.
  - `cpu_run` stays 0 through the reset.
- `DEPTH_WORDS`=4, stream 20 bytes:
  - Words 0..3 are written and the 5th is dropped.
  - `fault`=1 and `ld_words`=4.
